// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between the pipeline MEM
// stage (core port, priority) and a DMA / program-loader port that moves
// fixed-length word bursts. A DMA request waiting behind continuous core
// traffic is force-granted once the starvation counter reaches STARVE_LIMIT.
//
// DMA handshake: dma_req is a level held by the initiator until dma_gnt.
// dma_gnt pulses in the first burst cycle, which is also beat 0. On write
// bursts, dma_wready=1 means dma_wdata is consumed this cycle, one beat per
// cycle with no back-pressure. On read bursts, dma_rvalid=1 qualifies
// dma_rdata for exactly one cycle per beat, one cycle after that beat's RAM
// access. dma_done pulses the cycle after the final beat.
module data_mem_arbiter #(
   parameter int         STARVE_LIMIT = 8,
   parameter int         BURST_MAX    = 4,
   parameter logic [1:0] WR_WORD      = 2'b11,
   parameter logic [2:0] RD_WORD      = 3'b010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_req,
   input  logic [1:0]  core_write_ctrl,
   input  logic [2:0]  core_read_ctrl,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [3:0]  dma_burst_len,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_wready,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        dma_done,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic [1:0]  ram_write_ctrl,
   output logic [2:0]  ram_read_ctrl,
   input  logic [31:0] ram_rdata
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   localparam logic [3:0] BMAX  = 4'(BURST_MAX);

   typedef enum logic {
      S_CORE = 1'b0,
      S_DMA  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  starve_cnt;
   logic [3:0]  beat_cnt;
   logic [3:0]  beats;
   logic [3:0]  beats_clamped;
   logic [31:0] base;
   logic        dir;
   logic        grant;
   logic        last_beat;

   // The core always sees the RAM output directly; it only uses it in S_CORE.
   assign core_rdata = ram_rdata;

   // Requested burst length forced into 1..BURST_MAX.
   always_comb begin
      beats_clamped = dma_burst_len;
      if (dma_burst_len == 4'd0) begin
         beats_clamped = 4'd1;
      end else if (dma_burst_len > BMAX) begin
         beats_clamped = BMAX;
      end
   end

   assign grant     = (state == S_CORE) && dma_req && (!core_req || (starve_cnt == LIMIT));
   assign last_beat = (state == S_DMA) && (beat_cnt == (beats - 4'd1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_CORE;
      end else begin
         state <= state_nxt;
      end
   end

   // Burst bookkeeping, starvation counter and registered DMA read return.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 8'd0;
         beat_cnt   <= 4'd0;
         beats      <= 4'd0;
         base       <= 32'd0;
         dir        <= 1'b0;
         dma_rdata  <= 32'd0;
         dma_rvalid <= 1'b0;
         dma_done   <= 1'b0;
      end else begin
         dma_rvalid <= 1'b0;
         dma_done   <= 1'b0;
         if (grant) begin
            starve_cnt <= 8'd0;
            base       <= dma_addr & 32'hFFFF_FFFC;
            beats      <= beats_clamped;
            dir        <= dma_we;
            beat_cnt   <= 4'd0;
         end else if ((state == S_CORE) && dma_req && core_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 8'd1;
         end
         if (state == S_DMA) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (!dir) begin
               dma_rdata  <= ram_rdata;
               dma_rvalid <= 1'b1;
            end
            if (last_beat) begin
               dma_done <= 1'b1;
            end
         end
      end
   end

   // Next state and RAM port mux; the core owns the RAM unless a burst runs.
   always_comb begin
      state_nxt      = state;
      ram_addr       = core_addr;
      ram_wdata      = core_wdata;
      ram_write_ctrl = core_req ? core_write_ctrl : 2'b00;
      ram_read_ctrl  = core_req ? core_read_ctrl : 3'b000;
      core_stall     = 1'b0;
      dma_gnt        = 1'b0;
      dma_wready     = 1'b0;
      case (state)
         S_CORE: begin
            if (grant) begin
               state_nxt = S_DMA;
            end
         end
         S_DMA: begin
            ram_addr       = base + {26'd0, beat_cnt, 2'b00};
            ram_wdata      = dma_wdata;
            ram_write_ctrl = dir ? WR_WORD : 2'b00;
            ram_read_ctrl  = dir ? 3'b000 : RD_WORD;
            dma_wready     = dir;
            dma_gnt        = (beat_cnt == 4'd0);
            core_stall     = core_req;
            if (last_beat) begin
               state_nxt = S_CORE;
            end
         end
         default: begin
            state_nxt = S_CORE;
         end
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a word RAM model, an expected-memory image and
// an expected-read queue; each scenario task checks the arbiter cycle by cycle.
module tb_data_mem_arbiter;

   localparam int         STARVE_LIMIT = 8;
   localparam int         BURST_MAX    = 4;
   localparam logic [1:0] WR_WORD      = 2'b11;
   localparam logic [2:0] RD_WORD      = 3'b010;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req;
   logic [1:0]  core_write_ctrl;
   logic [2:0]  core_read_ctrl;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_addr;
   logic [3:0]  dma_burst_len;
   logic [31:0] dma_wdata;
   logic        dma_gnt;
   logic        dma_wready;
   logic        dma_rvalid;
   logic [31:0] dma_rdata;
   logic        dma_done;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [1:0]  ram_write_ctrl;
   logic [2:0]  ram_read_ctrl;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:255];
   logic [31:0] exp_mem [0:255];
   bit          init_done = 1'b0;
   logic [31:0] exp_q[$];
   int          total = 0;
   int          bad = 0;

   data_mem_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .BURST_MAX(BURST_MAX),
      .WR_WORD(WR_WORD),
      .RD_WORD(RD_WORD)
   ) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_write_ctrl(core_write_ctrl), .core_read_ctrl(core_read_ctrl),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_burst_len(dma_burst_len),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_wready(dma_wready), .dma_rvalid(dma_rvalid),
      .dma_rdata(dma_rdata), .dma_done(dma_done),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write_ctrl(ram_write_ctrl),
      .ram_read_ctrl(ram_read_ctrl), .ram_rdata(ram_rdata)
   );

   // Clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
   endfunction

   // RAM model: combinational read, full-word write on the rising edge.
   assign ram_rdata = mem[ram_addr[9:2]];
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) mem[i] = pat(i);
         init_done = 1'b1;
      end else if (ram_write_ctrl == WR_WORD) begin
         mem[ram_addr[9:2]] = ram_wdata;
      end
   end

   task automatic check_mem(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) n++;
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL %s mem_contents: words differing got=%0d exp=0", name, n);
      end
   endtask

   // One DMA burst checked cycle by cycle. Cycle 0 is the first S_CORE cycle
   // with dma_req high and a cleared starvation count.
   task automatic run_burst(input bit busy, input bit we, input logic [31:0] addr,
                            input logic [3:0] len, input bit hold, input int start_c);
      int          beats;
      int          wait_c;
      bit          in_dma;
      bit          e_rvalid;
      logic [31:0] base;
      logic [31:0] e_addr;
      logic [31:0] e_rd;
      logic [1:0]  ew;
      logic [2:0]  er;
      logic [9:0]  e_ctl;
      logic [9:0]  g_ctl;
      beats  = (len == 4'd0) ? 1 : ((int'(len) > BURST_MAX) ? BURST_MAX : int'(len));
      wait_c = busy ? STARVE_LIMIT + 1 : 1;
      base   = addr & 32'hFFFF_FFFC;
      for (int c = start_c; c <= wait_c + beats; c++) begin
         in_dma = (c >= wait_c) && (c < wait_c + beats);
         if (c < wait_c || hold) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_burst_len = len;
         end else begin
            dma_req = 1'b0; dma_we = 1'($urandom); dma_addr = $urandom; dma_burst_len = 4'($urandom);
         end
         core_req        = busy;
         core_write_ctrl = 2'($urandom);
         core_read_ctrl  = 3'($urandom);
         core_addr       = $urandom;
         core_wdata      = $urandom;
         dma_wdata       = $urandom;
         @(negedge clk);
         e_addr   = in_dma ? base + 32'(4 * (c - wait_c)) : core_addr;
         e_rvalid = !we && (c > wait_c) && (c <= wait_c + beats);
         if (in_dma) begin
            ew = we ? WR_WORD : 2'b00;
            er = we ? 3'b000 : RD_WORD;
         end else if (busy) begin
            ew = core_write_ctrl;
            er = core_read_ctrl;
         end else begin
            ew = 2'b00;
            er = 3'b000;
         end
         e_ctl = {in_dma && (c == wait_c), in_dma && busy, in_dma && we,
                  c == wait_c + beats, e_rvalid, ew, er};
         g_ctl = {dma_gnt, core_stall, dma_wready, dma_done, dma_rvalid, ram_write_ctrl, ram_read_ctrl};
         total++;
         if (g_ctl !== e_ctl) begin
            bad++;
            $display("FAIL ctl c=%0d: got %b exp %b (gnt stall wready done rvalid wctrl rctrl)", c, g_ctl, e_ctl);
         end
         total++;
         if (ram_addr !== e_addr) begin
            bad++;
            $display("FAIL ram_addr c=%0d: got %h exp %h", c, ram_addr, e_addr);
         end
         if (!in_dma || we) begin
            total++;
            if (ram_wdata !== (in_dma ? dma_wdata : core_wdata)) begin
               bad++;
               $display("FAIL ram_wdata c=%0d: got %h exp %h", c, ram_wdata, in_dma ? dma_wdata : core_wdata);
            end
         end
         total++;
         if (core_rdata !== exp_mem[e_addr[9:2]]) begin
            bad++;
            $display("FAIL core_rdata c=%0d: got %h exp %h", c, core_rdata, exp_mem[e_addr[9:2]]);
         end
         if (e_rvalid) begin
            e_rd = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            total++;
            if (dma_rdata !== e_rd) begin
               bad++;
               $display("FAIL dma_rdata c=%0d: got %h exp %h", c, dma_rdata, e_rd);
            end
         end
         if (in_dma && !we) exp_q.push_back(exp_mem[e_addr[9:2]]);
         if (in_dma && we) exp_mem[e_addr[9:2]] = dma_wdata;
         if (!in_dma && busy && (core_write_ctrl == WR_WORD)) exp_mem[e_addr[9:2]] = core_wdata;
         @(posedge clk);
         #1;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rd_queue: leftover got=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      core_req = 1'b1; core_write_ctrl = 2'b00; core_read_ctrl = RD_WORD;
      core_addr = 32'h40; core_wdata = 32'h1234_5678;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_burst_len = 4'd2; dma_wdata = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if ({dma_gnt, core_stall, dma_wready, dma_done, dma_rvalid, ram_write_ctrl, ram_read_ctrl}
             !== {5'b00000, 2'b00, RD_WORD}) begin
            bad++;
            $display("FAIL reset_ctl: got %b exp %b", {dma_gnt, core_stall, dma_wready, dma_done,
                     dma_rvalid, ram_write_ctrl, ram_read_ctrl}, {5'b00000, 2'b00, RD_WORD});
         end
         total++;
         if (dma_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_rdata: got %h exp 00000000", dma_rdata);
         end
         total++;
         if (ram_addr !== 32'h40 || core_rdata !== exp_mem[16]) begin
            bad++;
            $display("FAIL reset_passthru: got addr=%h rdata=%h exp addr=00000040 rdata=%h",
                     ram_addr, core_rdata, exp_mem[16]);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b1; dma_req = 1'b0; core_req = 1'b0;
   endtask

   task automatic test_core_only();
      core_req = 1'b1; core_write_ctrl = WR_WORD; core_read_ctrl = 3'b000;
      core_addr = 32'h40; core_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      total++;
      if ({core_stall, ram_write_ctrl, ram_read_ctrl, ram_addr, ram_wdata}
          !== {1'b0, WR_WORD, 3'b000, 32'h40, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL core_store: got stall=%b wc=%b rc=%b a=%h d=%h exp 0 11 000 00000040 deadbeef",
                  core_stall, ram_write_ctrl, ram_read_ctrl, ram_addr, ram_wdata);
      end
      exp_mem[16] = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      core_write_ctrl = 2'b00; core_read_ctrl = RD_WORD;
      @(negedge clk);
      total++;
      if ({core_stall, ram_write_ctrl, ram_read_ctrl, core_rdata} !== {1'b0, 2'b00, RD_WORD, exp_mem[16]}) begin
         bad++;
         $display("FAIL core_load: got stall=%b wc=%b rc=%b rdata=%h exp 0 00 010 %h",
                  core_stall, ram_write_ctrl, ram_read_ctrl, core_rdata, exp_mem[16]);
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         core_req = 1'($urandom); core_write_ctrl = 2'($urandom); core_read_ctrl = 3'($urandom);
         core_addr = $urandom; core_wdata = $urandom;
         @(negedge clk);
         total++;
         if ({core_stall, ram_write_ctrl, ram_read_ctrl, ram_addr, ram_wdata}
             !== {1'b0, core_req ? core_write_ctrl : 2'b00, core_req ? core_read_ctrl : 3'b000,
                  core_addr, core_wdata}) begin
            bad++;
            $display("FAIL core_mux k=%0d: got wc=%b rc=%b a=%h req=%b cwc=%b crc=%b ca=%h",
                     k, ram_write_ctrl, ram_read_ctrl, ram_addr, core_req, core_write_ctrl,
                     core_read_ctrl, core_addr);
         end
         if (core_req && core_write_ctrl == WR_WORD) exp_mem[core_addr[9:2]] = core_wdata;
      end
      @(posedge clk);
      #1;
      core_req = 1'b0;
      check_mem("core_only");
   endtask

   task automatic test_idle_grant();
      run_burst(1'b0, 1'b1, 32'h0000_0103, 4'd3, 1'b0, 0);
      check_mem("idle_grant");
   endtask

   task automatic test_starvation();
      run_burst(1'b1, 1'b0, 32'h0000_0080, 4'd2, 1'b0, 0);
      check_mem("starvation");
   endtask

   task automatic test_clamp_wrap();
      run_burst(1'b0, 1'b1, 32'h0000_0300, 4'd0, 1'b0, 0);
      run_burst(1'b0, 1'b0, 32'h0000_0310, 4'd15, 1'b0, 0);
      run_burst(1'b0, 1'b1, 32'hFFFF_FFFC, 4'd2, 1'b0, 0);
      run_burst(1'b1, 1'b0, 32'hFFFF_FFFE, 4'd2, 1'b0, 0);
      check_mem("clamp_wrap");
   endtask

   task automatic test_back_to_back();
      run_burst(1'b1, 1'b1, 32'h0000_0180, 4'd4, 1'b1, 0);
      run_burst(1'b1, 1'b0, 32'h0000_0180, 4'd4, 1'b0, 1);
      check_mem("back_to_back");
   endtask

   task automatic test_reset_mid_burst();
      core_req = 1'b0; core_write_ctrl = 2'b00; core_read_ctrl = 3'b000;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h240; dma_burst_len = 4'd4;
      @(posedge clk);
      #1;
      dma_req = 1'b0; dma_wdata = $urandom;
      @(negedge clk);
      total++;
      if ({dma_gnt, dma_wready, ram_write_ctrl, ram_addr} !== {1'b1, 1'b1, WR_WORD, 32'h240}) begin
         bad++;
         $display("FAIL rmb_beat1: got gnt=%b wr=%b wc=%b a=%h exp 1 1 11 00000240",
                  dma_gnt, dma_wready, ram_write_ctrl, ram_addr);
      end
      exp_mem[8'h90] = dma_wdata;
      @(posedge clk);
      #1;
      dma_wdata = $urandom;
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({dma_gnt, core_stall, dma_wready, dma_done, dma_rvalid, ram_write_ctrl, ram_read_ctrl, dma_rdata}
          !== 42'd0) begin
         bad++;
         $display("FAIL rmb_reset_outputs: got %b exp all zero", {dma_gnt, core_stall, dma_wready,
                  dma_done, dma_rvalid, ram_write_ctrl, ram_read_ctrl, dma_rdata});
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         core_req = 1'b1; core_write_ctrl = 2'b00; core_read_ctrl = RD_WORD; core_addr = $urandom;
         @(negedge clk);
         total++;
         if ({dma_gnt, core_stall, dma_wready, dma_done, dma_rvalid, ram_write_ctrl, ram_read_ctrl, ram_addr}
             !== {5'b00000, 2'b00, RD_WORD, core_addr}) begin
            bad++;
            $display("FAIL rmb_after k=%0d: got ctl=%b a=%h exp ctl=%b a=%h", k,
                     {dma_gnt, core_stall, dma_wready, dma_done, dma_rvalid, ram_write_ctrl, ram_read_ctrl},
                     ram_addr, {5'b00000, 2'b00, RD_WORD}, core_addr);
         end
         @(posedge clk);
         #1;
      end
      core_req = 1'b0;
      check_mem("reset_mid_burst");
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         run_burst(1'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 15)), 1'b0, 0);
      end
      check_mem("random");
   endtask

   initial begin
      reset = 1'b0;
      core_req = 1'b0; core_write_ctrl = 2'b00; core_read_ctrl = 3'b000;
      core_addr = 32'd0; core_wdata = 32'd0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_burst_len = 4'd0; dma_wdata = 32'd0;
      for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
      test_reset();
      test_core_only();
      test_idle_grant();
      test_starvation();
      test_clamp_wrap();
      test_back_to_back();
      test_reset_mid_burst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
